mem_arbiter2: RTL

Two-requester arbiter for the CPU's single 32-bit memory port. It grants the port to instruction fetch (requester 0) or data access (requester 1) and drives the 2:1 word-mux select that steers address, write data and write enable. It sequences each transfer through a req/ack handshake and returns read data with a one-cycle done pulse. It sits between the fetch/load-store units and the memory interface.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_mux2.sv | 16 +
 rtl/mem_arbiter2.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory-port arbiter.
package mem_arb_pkg;

    // Default data and address widths of the CPU memory port.
    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT = 32;

    // Requester indices, also the mux select value that steers each one.
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_mux2.sv
// Parameterised-width 2:1 combinational mux.
module arb_mux2 #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    input  logic         sel_i,
    output logic [W-1:0] out_o
);

    // Select in1 when sel_i is high, otherwise in0.
    always_comb begin
        out_o = sel_i ? in1_i : in0_i;
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-requester arbiter for the single memory port: instruction fetch (0) and
// data access (1). Each transfer is a req/ack handshake ending in a one-cycle
// done pulse with the read data captured in rdata.
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise requester 1 wins every tie.
module mem_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          we0,
    input  logic          we1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          sel,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned MW = AW + DW + 1;

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          mem_req_q, mem_req_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [DW-1:0] rdata_q, rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          last_q, last_d;
`endif

    logic          elig0, elig1, pick1;
    logic [MW-1:0] mux_out;
    logic          mux_we;

    // Eligibility masks a requester during its own done cycle; picks the winner.
    always_comb begin
        elig0 = req0 & ~done0_q;
        elig1 = req1 & ~done1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On a tie, favour whoever was not granted last.
        pick1 = elig1 & (~elig0 | (last_q == REQ_FETCH));
`else
        pick1 = elig1;
`endif
    end

    // Next-state and registered-output logic of the transfer FSM.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        mem_req_d = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata_d   = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    mem_req_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d    = pick1;
`endif
                    if (pick1) begin
                        state_d = BUSY1;
                        sel_d   = REQ_DATA;
                        gnt1_d  = 1'b1;
                    end else begin
                        state_d = BUSY0;
                        sel_d   = REQ_FETCH;
                        gnt0_d  = 1'b1;
                    end
                end
            end
            BUSY0: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    done0_d = 1'b1;
                    rdata_d = mem_rdata;
                end else begin
                    gnt0_d    = 1'b1;
                    mem_req_d = 1'b1;
                end
            end
            BUSY1: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    done1_d = 1'b1;
                    rdata_d = mem_rdata;
                end else begin
                    gnt1_d    = 1'b1;
                    mem_req_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= REQ_FETCH;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            mem_req_q <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= REQ_DATA;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            mem_req_q <= mem_req_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata_q   <= rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    // One shared mux steers address, write data and write enable.
    arb_mux2 #(
        .W (MW)
    ) u_mux (
        .in0_i (({addr0, wdata0, we0})),
        .in1_i (({addr1, wdata1, we1})),
        .sel_i (sel_q),
        .out_o (mux_out)
    );

    // Unpack mux result; write enable only reaches memory during a request.
    always_comb begin
        mem_addr  = mux_out[MW-1 -: AW];
        mem_wdata = mux_out[DW:1];
        mux_we    = mux_out[0];
        mem_we    = mux_we & mem_req_q;
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign rdata   = rdata_q;
    assign sel     = sel_q;
    assign mem_req = mem_req_q;

endmodule
